// File: rtl/seg7_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg7_scan_pkg
// Shared definitions for the seg7_scan display driver:
//   - scan_state_t : scan FSM states (SHOW = digit lit, BLANK = all anodes off)
//   - SEG_0..SEG_F : active-low segment codes, bit order {g,f,e,d,c,b,a}
//   - SEG_OFF      : all segments dark
//   - maxInt()     : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package seg7_scan_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b0000011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_D   = 7'b0100001;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_F   = 7'b0001110;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_scan_decode.sv
// -----------------------------------------------------------------------------
// seg7_scan_decode
// Combinational hex nibble to active-low 7-segment pattern.
// Ports:
//   i_nibble [3:0] : value 0-F to display
//   o_seg    [6:0] : cathodes, active-low, {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_scan_decode
  import seg7_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Time-multiplexed driver for a common-anode 7-segment display. Each digit is
// lit for HOLD_TICKS scan_ticks, followed by DEAD_TICKS scan_ticks with all
// anodes off. New values are staged by 'load' and only reach the display at a
// frame boundary so a frame never mixes old and new digits.
// Optional feature macro: SEG_BLINK_EN (blink digits selected by blink_mask,
// phase toggled by blink_tick). Without it those two inputs are ignored.
// Ports:
//   clk_in, rst        : clock, synchronous active-high reset
//   scan_tick          : 1-cycle refresh enable; all slot timing counts these
//   load, value, dp_in : stage a new value / decimal points
//   blink_mask/_tick   : blink control (SEG_BLINK_EN only)
//   an, seg, dp        : active-low anodes, cathodes {g..a}, decimal point
//   frame_done         : 1-cycle pulse when the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int HOLD_TICKS = 3,
  parameter int DEAD_TICKS = 1
)
(
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    scan_tick,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blink_tick,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int TW = $clog2(maxInt(HOLD_TICKS, DEAD_TICKS) + 1);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0] DEAD_LAST  = TW'((DEAD_TICKS > 0) ? DEAD_TICKS - 1 : 0);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam bit            NO_GAP     = (DEAD_TICKS == 0);

  scan_state_t               r_state;
  logic [TW-1:0]             r_tickCnt;
  logic [DW-1:0]             r_digit;
  logic [4*NUM_DIGITS-1:0]   r_stageVal;
  logic [NUM_DIGITS-1:0]     r_stageDp;
  logic [4*NUM_DIGITS-1:0]   r_dispVal;
  logic [NUM_DIGITS-1:0]     r_dispDp;
  logic [NUM_DIGITS-1:0]     r_an;
  logic [6:0]                r_seg;
  logic                      r_dp;
  logic                      r_frameDone;

  logic                      w_holdDone;
  logic                      w_deadDone;
  logic                      w_advance;
  logic                      w_wrap;
  logic [NUM_DIGITS-1:0]     w_digitSel;
  logic [NUM_DIGITS-1:0]     w_blinkOff;
  logic [3:0]                w_nibble;
  logic [6:0]                w_segDec;

  assign w_holdDone = scan_tick && (r_state == SHOW)  && (r_tickCnt == HOLD_LAST);
  assign w_deadDone = scan_tick && (r_state == BLANK) && (r_tickCnt == DEAD_LAST);
  // With no blank gap the digit advances straight out of SHOW.
  assign w_advance  = (w_holdDone && NO_GAP) || w_deadDone;
  assign w_wrap     = w_advance && (r_digit == DIGIT_LAST);

  assign w_digitSel = NUM_DIGITS'(1) << r_digit;
  assign w_nibble   = r_dispVal[4*r_digit +: 4];

  seg7_scan_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_segDec)
  );

`ifdef SEG_BLINK_EN
  logic r_phase;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_phase <= 1'b0;
    end else if (blink_tick) begin
      r_phase <= ~r_phase;
    end
  end

  // Blinked digits keep their slot but the anode stays off during phase 1.
  assign w_blinkOff = r_phase ? (blink_mask & w_digitSel) : '0;
`else
  logic w_unused_blink;
  assign w_unused_blink = ^{blink_mask, blink_tick};
  assign w_blinkOff     = '0;
`endif

  // Scan sequencing, staging and frame-boundary display update.
  // A load coinciding with the wrap bypasses staging so it shows at once.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= SHOW;
      r_tickCnt  <= '0;
      r_digit    <= '0;
      r_stageVal <= '0;
      r_stageDp  <= '0;
      r_dispVal  <= '0;
      r_dispDp   <= '0;
    end else begin
      if (load) begin
        r_stageVal <= value;
        r_stageDp  <= dp_in;
      end
      if (w_wrap) begin
        r_dispVal <= load ? value : r_stageVal;
        r_dispDp  <= load ? dp_in : r_stageDp;
      end
      if (scan_tick) begin
        case (r_state)
          SHOW: begin
            if (r_tickCnt == HOLD_LAST) begin
              r_tickCnt <= '0;
              if (!NO_GAP) r_state <= BLANK;
            end else begin
              r_tickCnt <= r_tickCnt + TW'(1);
            end
          end
          BLANK: begin
            if (r_tickCnt == DEAD_LAST) begin
              r_tickCnt <= '0;
              r_state   <= SHOW;
            end else begin
              r_tickCnt <= r_tickCnt + TW'(1);
            end
          end
          default: r_state <= SHOW;
        endcase
      end
      if (w_advance) begin
        r_digit <= w_wrap ? '0 : r_digit + DW'(1);
      end
    end
  end

  // Registered pin drivers: one clk_in behind the scan state.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_an        <= '1;
      r_seg       <= SEG_OFF;
      r_dp        <= 1'b1;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_wrap;
      if (r_state == SHOW) begin
        r_an  <= ~w_digitSel | w_blinkOff;
        r_seg <= w_segDec;
        r_dp  <= ~r_dispDp[r_digit];
      end else begin
        r_an  <= '1;
        r_seg <= SEG_OFF;
        r_dp  <= 1'b1;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan
// Directed self-checking bench for seg7_scan (4 digits, hold 3, dead 1).
// Build with +define+SEG_BLINK_EN to exercise the blink expectations.
// -----------------------------------------------------------------------------
module tb_seg7_scan;

  logic        clk_in     = 1'b0;
  logic        rst        = 1'b1;
  logic        scan_tick  = 1'b0;
  logic        load       = 1'b0;
  logic [15:0] value      = '0;
  logic [3:0]  dp_in      = '0;
  logic [3:0]  blink_mask = '0;
  logic        blink_tick = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int errors  = 0;
  int checks  = 0;
  int fdCount = 0;

  always #5 clk_in = ~clk_in;

  seg7_scan #(
    .NUM_DIGITS (4),
    .HOLD_TICKS (3),
    .DEAD_TICKS (1)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .scan_tick  (scan_tick),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .blink_mask (blink_mask),
    .blink_tick (blink_tick),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  // Each scan_tick spans 4 clocks; frame_done pulses seen are tallied.
  task automatic runTicks(input int n);
    for (int t = 0; t < n; t++) begin
      scan_tick = 1'b1;
      @(negedge clk_in);
      scan_tick = 1'b0;
      if (frame_done === 1'b1) fdCount++;
      repeat (3) begin
        @(negedge clk_in);
        if (frame_done === 1'b1) fdCount++;
      end
    end
  endtask

  task automatic pulseLoad(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk_in);
    load  = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      scan_tick = (c == 0);
      @(negedge clk_in);
      checks++;
      if ({an, seg, dp, frame_done} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL reset_hold%0d: got an=%b seg=%b dp=%b fd=%b expected an=1111 seg=1111111 dp=1 fd=0",
                 c, an, seg, dp, frame_done);
      end
    end
    scan_tick = 1'b0;
    rst = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_release: got an=%b seg=%b dp=%b expected an=1110 seg=1000000 dp=1", an, seg, dp);
    end
  endtask

  task automatic test_display();
    pulseLoad(16'h1234, 4'b0100);
    fdCount = 0;
    runTicks(8);
    checks++;
    if ({an, seg, dp} !== {4'b1011, 7'b1000000, 1'b1}) begin
      errors++;
      $display("[TB] FAIL old_frame_d2: got an=%b seg=%b dp=%b expected an=1011 seg=1000000 dp=1", an, seg, dp);
    end
    runTicks(8);
    checks++;
    if (fdCount !== 1) begin
      errors++;
      $display("[TB] FAIL frame_done_count: got %0d expected 1", fdCount);
    end
    checks++;
    if ({an, seg, dp} !== {4'b1110, 7'b0011001, 1'b1}) begin
      errors++;
      $display("[TB] FAIL new_d0: got an=%b seg=%b dp=%b expected an=1110 seg=0011001 dp=1", an, seg, dp);
    end
    runTicks(2);
    checks++;
    if ({an, seg, dp} !== {4'b1110, 7'b0011001, 1'b1}) begin
      errors++;
      $display("[TB] FAIL hold_d0: got an=%b seg=%b dp=%b expected an=1110 seg=0011001 dp=1", an, seg, dp);
    end
    runTicks(1);
    checks++;
    if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
      errors++;
      $display("[TB] FAIL blank_d0: got an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1", an, seg, dp);
    end
    runTicks(1);
    checks++;
    if ({an, seg, dp} !== {4'b1101, 7'b0110000, 1'b1}) begin
      errors++;
      $display("[TB] FAIL new_d1: got an=%b seg=%b dp=%b expected an=1101 seg=0110000 dp=1", an, seg, dp);
    end
    runTicks(4);
    checks++;
    if ({an, seg, dp} !== {4'b1011, 7'b0100100, 1'b0}) begin
      errors++;
      $display("[TB] FAIL new_d2: got an=%b seg=%b dp=%b expected an=1011 seg=0100100 dp=0", an, seg, dp);
    end
  endtask

  task automatic test_midframe_load();
    pulseLoad(16'hFFFF, 4'b1111);
    pulseLoad(16'hABCD, 4'b0000);
    fdCount = 0;
    runTicks(4);
    checks++;
    if ({an, seg, dp} !== {4'b0111, 7'b1111001, 1'b1}) begin
      errors++;
      $display("[TB] FAIL keep_old_d3: got an=%b seg=%b dp=%b expected an=0111 seg=1111001 dp=1", an, seg, dp);
    end
    runTicks(4);
    checks++;
    if ({an, seg, dp, fdCount[1:0]} !== {4'b1110, 7'b0100001, 1'b1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL last_load_d0: got an=%b seg=%b dp=%b fd=%0d expected an=1110 seg=0100001 dp=1 fd=1",
               an, seg, dp, fdCount);
    end
    runTicks(15);
    value     = 16'h5678;
    dp_in     = 4'b0001;
    load      = 1'b1;
    scan_tick = 1'b1;
    @(negedge clk_in);
    load      = 1'b0;
    scan_tick = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({an, seg, dp} !== {4'b1110, 7'b0000000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL bypass_d0: got an=%b seg=%b dp=%b expected an=1110 seg=0000000 dp=0", an, seg, dp);
    end
    runTicks(4);
    checks++;
    if ({an, seg, dp} !== {4'b1101, 7'b1111000, 1'b1}) begin
      errors++;
      $display("[TB] FAIL bypass_d1: got an=%b seg=%b dp=%b expected an=1101 seg=1111000 dp=1", an, seg, dp);
    end
  endtask

  task automatic test_freeze();
    int changed;
    changed = 0;
    runTicks(1);
    fdCount = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_in);
      if ({an, seg, dp} !== {4'b1101, 7'b1111000, 1'b1}) changed++;
      if (frame_done === 1'b1) fdCount++;
    end
    checks++;
    if (changed !== 0) begin
      errors++;
      $display("[TB] FAIL freeze_outputs: got %0d changed cycles expected 0", changed);
    end
    checks++;
    if (fdCount !== 0) begin
      errors++;
      $display("[TB] FAIL freeze_frame_done: got %0d pulses expected 0", fdCount);
    end
    runTicks(1);
    checks++;
    if (an !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL freeze_resume_lit: got an=%b expected an=1101", an);
    end
    runTicks(1);
    checks++;
    if (an !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL freeze_resume_blank: got an=%b expected an=1111", an);
    end
  endtask

  task automatic test_reset_blank();
    runTicks(4);
    checks++;
    if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
      errors++;
      $display("[TB] FAIL d2_blank: got an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1", an, seg, dp);
    end
    rst = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({an, seg, dp, frame_done} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midreset: got an=%b seg=%b dp=%b fd=%b expected an=1111 seg=1111111 dp=1 fd=0",
               an, seg, dp, frame_done);
    end
    rst = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      errors++;
      $display("[TB] FAIL midreset_d0: got an=%b seg=%b dp=%b expected an=1110 seg=1000000 dp=1", an, seg, dp);
    end
    fdCount = 0;
    runTicks(16);
    checks++;
    if ({an, seg, dp, fdCount[1:0]} !== {4'b1110, 7'b1000000, 1'b1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL staging_cleared: got an=%b seg=%b dp=%b fd=%0d expected an=1110 seg=1000000 dp=1 fd=1",
               an, seg, dp, fdCount);
    end
  endtask

  task automatic test_blink();
    logic [3:0] expBlink;
`ifdef SEG_BLINK_EN
    expBlink = 4'b1111;
`else
    expBlink = 4'b1110;
`endif
    blink_mask = 4'b0001;
    blink_tick = 1'b1;
    @(negedge clk_in);
    blink_tick = 1'b0;
    @(negedge clk_in);
    checks++;
    if (an !== expBlink) begin
      errors++;
      $display("[TB] FAIL blink_d0: got an=%b expected an=%b", an, expBlink);
    end
    runTicks(4);
    checks++;
    if (an !== 4'b1101) begin
      errors++;
      $display("[TB] FAIL blink_d1_normal: got an=%b expected an=1101", an);
    end
    runTicks(12);
    checks++;
    if (an !== expBlink) begin
      errors++;
      $display("[TB] FAIL blink_d0_next_frame: got an=%b expected an=%b", an, expBlink);
    end
    blink_tick = 1'b1;
    @(negedge clk_in);
    blink_tick = 1'b0;
    @(negedge clk_in);
    checks++;
    if (an !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL blink_restore: got an=%b expected an=1110", an);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_display();
    test_midframe_load();
    test_freeze();
    test_reset_blank();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
